instr_mem_arbiter: RTL and testbench

Shares the single-port instruction RAM between the RISC-V core fetch port and a program-loader port (UART or debug bootloader) using a req/gnt/rvalid handshake. It produces a real `instr_gnt_i` for the core, so the core's grant is no longer tied to its own request. It also owns boot sequencing: core fetch is held off until the loader reports that the image is written. It sits between `riscv_core`, the loader master and `instr_ram_wrap`, all in the `clk` domain.

---
 rtl/instr_mem_arb_pkg.sv | 16 +
 rtl/instr_mem_arbiter_if.sv | 49 ++++
 rtl/instr_mem_arbiter_rr_arbiter2.sv | 34 +++
 rtl/instr_mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_instr_mem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_mem_arb_pkg.sv
// Shared types and constants for the instruction-RAM arbiter between core fetch and program loader.
package instr_mem_arb_pkg;

  typedef enum logic {
    OWNER_CORE   = 1'b0,
    OWNER_LOADER = 1'b1
  } owner_e;

  typedef enum logic {
    BOOT_HOLD = 1'b0,
    BOOT_RUN  = 1'b1
  } boot_state_e;

  localparam int CONFLICT_CNT_W = 16;

endpackage

// File: rtl/instr_mem_arbiter_if.sv
// Bus bundle for instr_mem_arbiter: core fetch port, loader port and the single-port RAM port.
interface instr_mem_arbiter_if #(
  parameter int ADDR_WIDTH     = 32,
  parameter int RAM_ADDR_WIDTH = 14,
  parameter int DATA_WIDTH     = 32
);
  logic                        core_req_i;
  logic                        core_gnt_o;
  logic                        core_rvalid_o;
  logic [ADDR_WIDTH-1:0]       core_addr_i;
  logic [DATA_WIDTH-1:0]       core_rdata_o;

  logic                        ld_req_i;
  logic                        ld_gnt_o;
  logic                        ld_rvalid_o;
  logic                        ld_we_i;
  logic [DATA_WIDTH/8-1:0]     ld_be_i;
  logic [ADDR_WIDTH-1:0]       ld_addr_i;
  logic [DATA_WIDTH-1:0]       ld_wdata_i;
  logic [DATA_WIDTH-1:0]       ld_rdata_o;

  logic                        mem_en_o;
  logic                        mem_we_o;
  logic [DATA_WIDTH/8-1:0]     mem_be_o;
  logic [RAM_ADDR_WIDTH-1:0]   mem_addr_o;
  logic [DATA_WIDTH-1:0]       mem_wdata_o;
  logic [DATA_WIDTH-1:0]       mem_rdata_i;

  // Arbiter side
  modport slave (
    input  core_req_i, core_addr_i,
    input  ld_req_i, ld_we_i, ld_be_i, ld_addr_i, ld_wdata_i,
    input  mem_rdata_i,
    output core_gnt_o, core_rvalid_o, core_rdata_o,
    output ld_gnt_o, ld_rvalid_o, ld_rdata_o,
    output mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );

  // Requesters and RAM side
  modport master (
    output core_req_i, core_addr_i,
    output ld_req_i, ld_we_i, ld_be_i, ld_addr_i, ld_wdata_i,
    output mem_rdata_i,
    input  core_gnt_o, core_rvalid_o, core_rdata_o,
    input  ld_gnt_o, ld_rvalid_o, ld_rdata_o,
    input  mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );

endinterface

// File: rtl/instr_mem_arbiter_rr_arbiter2.sv
// Two-way round-robin grant logic; last_owner flips priority so a tie goes to whoever was not served last.
module rr_arbiter2
  import instr_mem_arb_pkg::*;
(
  input  logic clk,
  input  logic reset_n_sync,
  input  logic req_core,
  input  logic req_loader,
  output logic gnt_core,
  output logic gnt_loader
);

  owner_e last_owner;

  always_comb begin
    gnt_core   = 1'b0;
    gnt_loader = 1'b0;
    if (req_core && req_loader) begin
      if (last_owner == OWNER_LOADER) gnt_core   = 1'b1;
      else                            gnt_loader = 1'b1;
    end else begin
      gnt_core   = req_core;
      gnt_loader = req_loader;
    end
  end

  // Reset to LOADER so the core wins the first tie
  always_ff @(posedge clk or negedge reset_n_sync) begin
    if (!reset_n_sync)   last_owner <= OWNER_LOADER;
    else if (gnt_core)   last_owner <= OWNER_CORE;
    else if (gnt_loader) last_owner <= OWNER_LOADER;
  end

endmodule

// File: rtl/instr_mem_arbiter.sv
// Shares the instruction RAM between core fetch and the program loader, with boot hold-off of core fetch.
// Boot FSM is present only when INSTR_MEM_ARB_BOOT_HOLD_EN is defined; otherwise the block always runs.
module instr_mem_arbiter
  import instr_mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int RAM_ADDR_WIDTH = 14,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      reset_n_sync,
  instr_mem_arbiter_if.slave        bus,
  input  logic                      loader_done_i,
  input  logic                      fetch_enable_i,
  output logic                      fetch_enable_o,
  output logic [CONFLICT_CNT_W-1:0] conflict_cnt_o
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  function automatic logic [CONFLICT_CNT_W-1:0] sat_inc(input logic [CONFLICT_CNT_W-1:0] v);
    return (&v) ? v : v + {{(CONFLICT_CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic core_run;

`ifdef INSTR_MEM_ARB_BOOT_HOLD_EN
  boot_state_e boot_state;

  always_ff @(posedge clk or negedge reset_n_sync) begin
    if (!reset_n_sync) begin
      boot_state <= BOOT_HOLD;
    end else begin
      case (boot_state)
        BOOT_HOLD: if (loader_done_i) boot_state <= BOOT_RUN;
        BOOT_RUN:  boot_state <= BOOT_RUN;
        default:   boot_state <= BOOT_HOLD;
      endcase
    end
  end

  assign core_run = (boot_state == BOOT_RUN);
`else
  logic unused_loader_done;
  assign unused_loader_done = loader_done_i;
  assign core_run           = 1'b1;
`endif

  assign fetch_enable_o = core_run & fetch_enable_i;

  // Grant stage: a held-off core simply does not compete
  logic gnt_core;
  logic gnt_loader;

  rr_arbiter2 u_rr_arbiter2 (
    .clk          (clk),
    .reset_n_sync (reset_n_sync),
    .req_core     (bus.core_req_i & core_run),
    .req_loader   (bus.ld_req_i),
    .gnt_core     (gnt_core),
    .gnt_loader   (gnt_loader)
  );

  assign bus.core_gnt_o = gnt_core;
  assign bus.ld_gnt_o   = gnt_loader;

  always_comb begin
    bus.mem_en_o    = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_be_o    = '0;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    if (gnt_loader) begin
      bus.mem_en_o    = 1'b1;
      bus.mem_we_o    = bus.ld_we_i;
      bus.mem_be_o    = bus.ld_be_i;
      bus.mem_addr_o  = bus.ld_addr_i[RAM_ADDR_WIDTH+1:2];
      bus.mem_wdata_o = bus.ld_wdata_i;
    end else if (gnt_core) begin
      bus.mem_en_o    = 1'b1;
      bus.mem_be_o    = {BE_WIDTH{1'b1}};
      bus.mem_addr_o  = bus.core_addr_i[RAM_ADDR_WIDTH+1:2];
    end
  end

  // Upper address bits wrap modulo RAM size; byte offset is irrelevant for word access
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.core_addr_i[ADDR_WIDTH-1:RAM_ADDR_WIDTH+2], bus.core_addr_i[1:0],
                              bus.ld_addr_i[ADDR_WIDTH-1:RAM_ADDR_WIDTH+2], bus.ld_addr_i[1:0]};

  // Response stage: RAM data arrives one cycle after the grant
  owner_e                owner_q;
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] core_rdata_q;
  logic [DATA_WIDTH-1:0] ld_rdata_q;
  logic                  core_rvalid;
  logic                  ld_rvalid;

  always_ff @(posedge clk or negedge reset_n_sync) begin
    if (!reset_n_sync) begin
      valid_q <= 1'b0;
      owner_q <= OWNER_LOADER;
    end else begin
      valid_q <= gnt_core | gnt_loader;
      if (gnt_loader)    owner_q <= OWNER_LOADER;
      else if (gnt_core) owner_q <= OWNER_CORE;
    end
  end

  assign core_rvalid = valid_q && (owner_q == OWNER_CORE);
  assign ld_rvalid   = valid_q && (owner_q == OWNER_LOADER);

  always_ff @(posedge clk or negedge reset_n_sync) begin
    if (!reset_n_sync) begin
      core_rdata_q <= '0;
      ld_rdata_q   <= '0;
    end else begin
      if (core_rvalid) core_rdata_q <= bus.mem_rdata_i;
      if (ld_rvalid)   ld_rdata_q   <= bus.mem_rdata_i;
    end
  end

  assign bus.core_rvalid_o = core_rvalid;
  assign bus.ld_rvalid_o   = ld_rvalid;
  assign bus.core_rdata_o  = core_rvalid ? bus.mem_rdata_i : core_rdata_q;
  assign bus.ld_rdata_o    = ld_rvalid   ? bus.mem_rdata_i : ld_rdata_q;

  logic                      denied;
  logic [CONFLICT_CNT_W-1:0] conflict_cnt_q;

  assign denied = (bus.core_req_i & ~gnt_core) | (bus.ld_req_i & ~gnt_loader);

  always_ff @(posedge clk or negedge reset_n_sync) begin
    if (!reset_n_sync) conflict_cnt_q <= '0;
    else if (denied)   conflict_cnt_q <= sat_inc(conflict_cnt_q);
  end

  assign conflict_cnt_o = conflict_cnt_q;

endmodule

// File: tb/tb_instr_mem_arbiter.sv
// Scoreboard bench for instr_mem_arbiter: random/directed traffic checked against a spec-level model.
module tb_instr_mem_arbiter;
  import instr_mem_arb_pkg::*;

  localparam int AW = 32, RAW = 14, DW = 32, WORDS = 1 << RAW;
`ifdef INSTR_MEM_ARB_BOOT_HOLD_EN
  localparam bit HOLD_MODE = 1'b1;
`else
  localparam bit HOLD_MODE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n_sync = 1'b0;
  logic        loader_done_i = 1'b0;
  logic        fetch_enable_i = 1'b1;
  logic        fetch_enable_o;
  logic [15:0] conflict_cnt_o;

  instr_mem_arbiter_if #(.ADDR_WIDTH(AW), .RAM_ADDR_WIDTH(RAW), .DATA_WIDTH(DW)) bus ();

  instr_mem_arbiter #(.ADDR_WIDTH(AW), .RAM_ADDR_WIDTH(RAW), .DATA_WIDTH(DW)) dut (
    .clk            (clk),
    .reset_n_sync   (reset_n_sync),
    .bus            (bus),
    .loader_done_i  (loader_done_i),
    .fetch_enable_i (fetch_enable_i),
    .fetch_enable_o (fetch_enable_o),
    .conflict_cnt_o (conflict_cnt_o)
  );

  always #5 clk = ~clk;

  // RAM: read data one cycle after enable
  logic [31:0] ram [WORDS] = '{default: 32'h0};
  always @(posedge clk) begin
    if (bus.mem_en_o) begin
      if (bus.mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_be_o[b]) ram[bus.mem_addr_o][8*b +: 8] <= bus.mem_wdata_o[8*b +: 8];
      end else begin
        bus.mem_rdata_i <= ram[bus.mem_addr_o];
      end
    end
  end

  int errors = 0, checks = 0;
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endfunction

  typedef struct { logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] wdata; bit done; } cmd_t;
  typedef struct { logic [31:0] data; bit wr; int unsigned stamp; } rsp_t;
  cmd_t core_cmds[$], ld_cmds[$];
  rsp_t core_q[$], ld_q[$];

  // Reference model state
  int unsigned cyc = 0;
  bit          run_m;
  owner_e      last_m;
  int          cnt_m;
  logic [31:0] ref_mem [WORDS] = '{default: 32'h0};
  logic [31:0] core_last, ld_last;
  bit          ld_known;

  function automatic int widx(logic [31:0] a);
    return int'((a / 32'd4) % WORDS);
  endfunction

  function automatic void model_reset();
    run_m = !HOLD_MODE; last_m = OWNER_LOADER; cnt_m = 0;
    core_last = 32'h0; ld_last = 32'h0; ld_known = 1'b1;
    core_q.delete(); ld_q.delete(); core_cmds.delete(); ld_cmds.delete();
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle prediction of grants, RAM port and counter; pushes expected responses
  always @(negedge clk) begin
    if (reset_n_sync) begin
      bit ec, el;
      int w;
      ec = bus.core_req_i && run_m;
      el = bus.ld_req_i;
      if (ec && el) begin
        if (last_m == OWNER_LOADER) el = 1'b0;
        else                        ec = 1'b0;
      end
      chk("core_gnt", bus.core_gnt_o, ec);
      chk("ld_gnt", bus.ld_gnt_o, el);
      chk("mem_en", bus.mem_en_o, ec | el);
      chk("fetch_enable", fetch_enable_o, run_m ? fetch_enable_i : 1'b0);
      chk("conflict_cnt", conflict_cnt_o, cnt_m);
      if (ec) begin
        w = widx(bus.core_addr_i);
        chk("core_mem_we", bus.mem_we_o, 1'b0);
        chk("core_mem_be", bus.mem_be_o, 4'hF);
        chk("core_mem_addr", bus.mem_addr_o, w);
        core_q.push_back('{data: ref_mem[w], wr: 1'b0, stamp: cyc});
        last_m = OWNER_CORE;
      end
      if (el) begin
        w = widx(bus.ld_addr_i);
        chk("ld_mem_we", bus.mem_we_o, bus.ld_we_i);
        chk("ld_mem_be", bus.mem_be_o, bus.ld_be_i);
        chk("ld_mem_addr", bus.mem_addr_o, w);
        if (bus.ld_we_i) begin
          chk("ld_mem_wdata", bus.mem_wdata_o, bus.ld_wdata_i);
          for (int b = 0; b < 4; b++)
            if (bus.ld_be_i[b]) ref_mem[w][8*b +: 8] = bus.ld_wdata_i[8*b +: 8];
        end
        ld_q.push_back('{data: ref_mem[w], wr: bus.ld_we_i, stamp: cyc});
        last_m = OWNER_LOADER;
      end
      if ((bus.core_req_i && !ec) || (bus.ld_req_i && !el))
        cnt_m = (cnt_m < 65535) ? cnt_m + 1 : 65535;
      if (HOLD_MODE && loader_done_i) run_m = 1'b1;
    end
  end

  // Response monitor
  always @(negedge clk) begin
    if (reset_n_sync) begin
      rsp_t e;
      if (bus.core_rvalid_o) begin
        if (core_q.size() == 0) chk("core_spurious_rvalid", 1, 0);
        else begin
          e = core_q.pop_front();
          chk("core_rvalid_latency", cyc - e.stamp, 1);
          chk("core_rdata", bus.core_rdata_o, e.data);
          core_last = e.data;
        end
      end else begin
        if (core_q.size() != 0 && core_q[0].stamp < cyc) begin
          chk("core_missing_rvalid", 0, 1);
          void'(core_q.pop_front());
        end
        chk("core_rdata_hold", bus.core_rdata_o, core_last);
      end
      if (bus.ld_rvalid_o) begin
        if (ld_q.size() == 0) chk("ld_spurious_rvalid", 1, 0);
        else begin
          e = ld_q.pop_front();
          chk("ld_rvalid_latency", cyc - e.stamp, 1);
          if (!e.wr) begin
            chk("ld_rdata", bus.ld_rdata_o, e.data);
            ld_last = e.data; ld_known = 1'b1;
          end else ld_known = 1'b0;
        end
      end else begin
        if (ld_q.size() != 0 && ld_q[0].stamp < cyc) begin
          chk("ld_missing_rvalid", 0, 1);
          void'(ld_q.pop_front());
        end
        if (ld_known) chk("ld_rdata_hold", bus.ld_rdata_o, ld_last);
      end
    end
  end

  // Requester driver: presents queued commands, holds each until granted
  initial begin
    bit cg, lg;
    cmd_t c;
    bus.core_req_i = 0; bus.core_addr_i = 0;
    bus.ld_req_i = 0; bus.ld_we_i = 0; bus.ld_be_i = 0; bus.ld_addr_i = 0; bus.ld_wdata_i = 0;
    forever begin
      @(negedge clk);
      cg = bus.core_gnt_o; lg = bus.ld_gnt_o;
      @(posedge clk); #1;
      loader_done_i = 1'b0;
      if (!reset_n_sync) begin
        bus.core_req_i = 1'b0; bus.ld_req_i = 1'b0;
      end else begin
        if (bus.core_req_i && cg) bus.core_req_i = 1'b0;
        if (!bus.core_req_i && core_cmds.size() > 0) begin
          c = core_cmds.pop_front();
          bus.core_req_i = 1'b1; bus.core_addr_i = c.addr;
        end
        if (bus.ld_req_i && lg) bus.ld_req_i = 1'b0;
        if (!bus.ld_req_i && ld_cmds.size() > 0) begin
          c = ld_cmds.pop_front();
          bus.ld_req_i = 1'b1; bus.ld_we_i = c.we; bus.ld_be_i = c.be;
          bus.ld_addr_i = c.addr; bus.ld_wdata_i = c.wdata;
          loader_done_i = c.done;
        end
      end
    end
  end

  function automatic cmd_t mk(logic we, logic [3:0] be, logic [31:0] a, logic [31:0] d, bit done);
    cmd_t c;
    c.we = we; c.be = be; c.addr = a; c.wdata = d; c.done = done;
    return c;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
    if ($urandom_range(0, 1) == 1) a = a + 32'h0001_0000;
    if ($urandom_range(0, 7) == 0) a = a | 32'h8000_0000;
    return a;
  endfunction

  function automatic cmd_t rand_ld();
    return mk(1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), rand_addr(), $urandom(), 1'b0);
  endfunction

  task automatic drain();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 300 && !idle; i++) begin
      @(posedge clk); #1;
      idle = core_cmds.size() == 0 && ld_cmds.size() == 0 && !bus.core_req_i && !bus.ld_req_i &&
             core_q.size() == 0 && ld_q.size() == 0;
    end
    if (!idle) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    bit seen;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_core_gnt", bus.core_gnt_o, 0);
    chk("rst_ld_gnt", bus.ld_gnt_o, 0);
    chk("rst_core_rvalid", bus.core_rvalid_o, 0);
    chk("rst_ld_rvalid", bus.ld_rvalid_o, 0);
    chk("rst_mem_en", bus.mem_en_o, 0);
    chk("rst_cnt", conflict_cnt_o, 0);
    chk("rst_core_rdata", bus.core_rdata_o, 0);
    chk("rst_ld_rdata", bus.ld_rdata_o, 0);
    chk("rst_fetch_enable", fetch_enable_o, HOLD_MODE ? 1'b0 : 1'b1);
    @(posedge clk); #1;
    reset_n_sync = 1'b1;

    // Core held off during boot while the loader writes the image
    core_cmds.push_back(mk(0, 4'hF, 32'h0, 0, 0));
    repeat (3) begin @(posedge clk); #1; end
    ld_cmds.push_back(mk(1, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF, 0));
    ld_cmds.push_back(mk(1, 4'hF, 32'h0001_0000, 32'h1234_5678, 0));
    ld_cmds.push_back(mk(1, 4'b0101, 32'h0000_0104, 32'hCAFE_F00D, 1));
    core_cmds.push_back(mk(0, 4'hF, 32'h0000_0100, 0, 0));
    ld_cmds.push_back(mk(0, 4'hF, 32'h0000_0104, 0, 0));
    drain();

    // Both ports saturating the RAM
    for (int i = 0; i < 6; i++) begin
      core_cmds.push_back(mk(0, 4'hF, 32'h100 + 32'(4 * i), 0, 0));
      ld_cmds.push_back(rand_ld());
    end
    drain();

    for (int i = 0; i < 400; i++) begin
      if (core_cmds.size() < 3 && $urandom_range(0, 2) != 0) core_cmds.push_back(mk(0, 4'hF, rand_addr(), 0, 0));
      if (ld_cmds.size() < 3 && $urandom_range(0, 2) != 0) ld_cmds.push_back(rand_ld());
      fetch_enable_i = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    fetch_enable_i = 1'b1;
    drain();

    // Reset in the cycle after a grant drops the pending response
    core_cmds.push_back(mk(0, 4'hF, 32'h100, 0, 0));
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus.core_gnt_o;
    end
    if (!seen) chk("reset_test_grant_timeout", 0, 1);
    @(posedge clk); #1;
    reset_n_sync = 1'b0;
    model_reset();
    @(negedge clk);
    chk("midrst_core_rvalid", bus.core_rvalid_o, 0);
    chk("midrst_ld_rvalid", bus.ld_rvalid_o, 0);
    chk("midrst_cnt", conflict_cnt_o, 0);
    chk("midrst_fetch_enable", fetch_enable_o, HOLD_MODE ? 1'b0 : 1'b1);
    @(posedge clk); #1;
    reset_n_sync = 1'b1;
    core_cmds.push_back(mk(0, 4'hF, 32'h104, 0, 0));
    repeat (2) begin @(posedge clk); #1; end
    ld_cmds.push_back(mk(1, 4'hF, 32'h200, 32'h0BAD_F00D, 1));
    drain();

    // Continuous contention long enough to saturate the counter
    for (int i = 0; i < 65600; i++) begin
      if (core_cmds.size() < 2) core_cmds.push_back(mk(0, 4'hF, rand_addr(), 0, 0));
      if (ld_cmds.size() < 2) ld_cmds.push_back(rand_ld());
      @(posedge clk); #1;
    end
    drain();
    @(negedge clk);
    chk("cnt_saturated", conflict_cnt_o, 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
